// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DACC   = 3'd1,
      FACC   = 3'd2,
      DUMP   = 3'd3,
      HALTED = 3'd4
   } arbState_t;

   localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant selection between data and fetch requesters, with a bounded
// starvation counter so a pending fetch eventually wins.
module arb_select
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic dReq,
   input  logic fReq,
   output logic grantData,
   output logic grantFetch
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starveCnt;
   logic          belowMax;

   assign belowMax = (starveCnt < CW'(STARVE_MAX));

   always_comb begin
      grantData  = 1'b0;
      grantFetch = 1'b0;
      if (en) begin
         if (dReq && belowMax) begin
            grantData = 1'b1;
         end else if (fReq) begin
            grantFetch = 1'b1;
         end else if (dReq) begin
            grantData = 1'b1;
         end
      end
   end

   // Counts data grants only while a fetch is waiting; any idle fetch
   // line or fetch grant starts the count over.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starveCnt <= '0;
      end else if (grantFetch || !fReq) begin
         starveCnt <= '0;
      end else if (grantData && belowMax) begin
         starveCnt <= starveCnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access,
// handles misaligned data errors and a halt/dump sequence.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   input  logic        halt,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        mem_en,
   output logic        mem_wr,
   output logic        mem_createdump,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        if_valid,
   output logic        d_valid,
   output logic [15:0] if_rdata,
   output logic [15:0] d_rdata,
   output logic        if_stall,
   output logic        d_stall,
   output logic        d_err,
   output logic [2:0]  dbgState
);

   arbState_t   state, nextState;
   logic        haltPending;
   logic        dReq;
   logic        grantEn, grantData, grantFetch;
   logic        accWr;
   logic [15:0] addrReg, wdataReg;

   assign dReq    = d_rd | d_wr;
   assign grantEn = (state == IDLE) && !haltPending;

   arb_select #(
      .STARVE_MAX(STARVE_MAX)
   ) uSelect (
      .clk       (clk),
      .rst       (rst),
      .en        (grantEn),
      .dReq      (dReq),
      .fReq      (if_req),
      .grantData (grantData),
      .grantFetch(grantFetch)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            // A halt latched during an earlier access wins over new grants.
            if (haltPending) begin
               nextState = DUMP;
            end else if (grantFetch) begin
               nextState = FACC;
            end else if (grantData) begin
               nextState = d_addr[0] ? IDLE : DACC;
            end else if (halt) begin
               nextState = DUMP;
            end
         end
         DACC, FACC: begin
            if (mem_done) begin
               nextState = IDLE;
            end
         end
         DUMP:    nextState = HALTED;
         HALTED:  nextState = HALTED;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         haltPending <= 1'b0;
         accWr       <= 1'b0;
         addrReg     <= 16'h0000;
         wdataReg    <= 16'h0000;
         if_valid    <= 1'b0;
         d_valid     <= 1'b0;
         d_err       <= 1'b0;
         if_rdata    <= 16'h0000;
         d_rdata     <= 16'h0000;
      end else begin
         state    <= nextState;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         if (halt) begin
            haltPending <= 1'b1;
         end
         if (grantFetch) begin
            addrReg  <= if_addr;
            wdataReg <= 16'h0000;
            accWr    <= 1'b0;
         end else if (grantData) begin
            if (d_addr[0]) begin
               d_err   <= 1'b1;
               d_valid <= 1'b1;
               d_rdata <= 16'h0000;
            end else begin
               addrReg  <= d_addr;
               wdataReg <= d_wdata;
               accWr    <= d_wr;
            end
         end
         if (state == FACC && mem_done) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
         end
         if (state == DACC && mem_done) begin
            d_rdata <= accWr ? 16'h0000 : mem_rdata;
            d_valid <= 1'b1;
         end
      end
   end

   assign mem_en         = (state == DACC) || (state == FACC);
   assign mem_wr         = (state == DACC) && accWr;
   assign mem_createdump = (state == DUMP);
   assign mem_addr       = addrReg;
   assign mem_wdata      = wdataReg;
   assign d_stall        = dReq & ~d_valid;
   assign if_stall       = if_req & ~if_valid;
   assign dbgState       = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random two-requester traffic against
// a queue-based reference, plus directed latency, starvation, error, halt and reset cases.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = 16'h0;
   logic        d_rd = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = 16'h0;
   logic [15:0] d_wdata = 16'h0;
   logic        halt = 1'b0;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_done = 1'b0;
   logic        mem_en, mem_wr, mem_createdump;
   logic [15:0] mem_addr, mem_wdata;
   logic        if_valid, d_valid;
   logic [15:0] if_rdata, d_rdata;
   logic        if_stall, d_stall, d_err;
   logic [2:0]  dbgState;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];
   logic [15:0] fexp_q[$];
   int memDelay = 0;
   bit spurious = 1'b0;
   int starveRun = 0;

   mem_arbiter #(.STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .halt(halt), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_createdump(mem_createdump),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_valid(if_valid), .d_valid(d_valid), .if_rdata(if_rdata), .d_rdata(d_rdata),
      .if_stall(if_stall), .d_stall(d_stall), .d_err(d_err), .dbgState(dbgState)
   );

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return a ^ 16'hBEFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   initial begin : memModel
      int waitCnt = 0;
      int curDelay = 0;
      forever begin
         @(negedge clk);
         if (rst && mem_en) begin
            if (mem_addr[15]) begin
               chk("mem_fetch_addr", mem_addr, if_addr);
               chk("mem_fetch_wr", mem_wr, 1'b0);
            end else begin
               chk("mem_data_addr", mem_addr, d_addr);
               chk("mem_data_wr", mem_wr, d_wr);
               if (d_wr) chk("mem_data_wdata", mem_wdata, d_wdata);
            end
            if (waitCnt == 0) curDelay = (memDelay < 0) ? $urandom_range(0, 3) : memDelay;
            mem_done  = (waitCnt == curDelay);
            mem_rdata = memWord(mem_addr);
            waitCnt++;
         end else begin
            waitCnt   = 0;
            mem_done  = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
            mem_rdata = 16'($urandom);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic [16:0] e;
      logic [15:0] f;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("d_stall", d_stall, (d_rd | d_wr) & ~d_valid);
            chk("if_stall", if_stall, if_req & ~if_valid);
            if (d_valid) begin
               if (exp_q.size() == 0) chk("d_unexpected_valid", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("d_err", d_err, e[16]);
                  chk("d_rdata", d_rdata, e[15:0]);
               end
               if (if_req) starveRun++;
            end else begin
               chk("d_err_without_valid", d_err, 1'b0);
            end
            if (if_valid) begin
               if (fexp_q.size() == 0) chk("if_unexpected_valid", 1, 0);
               else begin
                  f = fexp_q.pop_front();
                  chk("if_rdata", if_rdata, f);
               end
               chk("starve_bound", starveRun <= STARVE + 1, 1'b1);
               starveRun = 0;
            end else if (!if_req) begin
               starveRun = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic waitFor(input bit isData, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (isData ? d_valid : if_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk(isData ? "d_valid_timeout" : "if_valid_timeout", 0, 1);
      #2;
   endtask

   task automatic doReset();
      @(negedge clk);
      #2 rst = 1'b0;
      if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_createdump", mem_createdump, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_mem_wdata", mem_wdata, 16'h0);
      chk("rst_valids_err", {if_valid, d_valid, d_err}, 3'b000);
      chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
      exp_q.delete();
      fexp_q.delete();
      starveRun = 0;
      #2 rst = 1'b1;
   endtask

   task automatic dataDriver(input int n);
      bit ok;
      bit wr, mis;
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, 3);
         if (gap > 0) begin
            d_rd = 1'b0; d_wr = 1'b0;
            repeat (gap) begin @(negedge clk); #2; end
         end
         wr  = 1'($urandom_range(0, 1));
         mis = ($urandom_range(0, 5) == 0);
         a = 16'($urandom);
         a[15] = 1'b0;
         a[0]  = mis;
         d_addr = a;
         d_wdata = 16'($urandom);
         d_rd = !wr;
         d_wr = wr;
         if (mis) exp_q.push_back({1'b1, 16'h0000});
         else if (wr) exp_q.push_back({1'b0, 16'h0000});
         else exp_q.push_back({1'b0, memWord(a)});
         waitFor(1'b1, 300, ok);
         if (!ok) break;
      end
      d_rd = 1'b0; d_wr = 1'b0;
   endtask

   task automatic fetchDriver(input int n);
      bit ok;
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, 4);
         if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) begin @(negedge clk); #2; end
         end
         a = 16'($urandom);
         a[15] = 1'b1;
         if_addr = a;
         if_req = 1'b1;
         fexp_q.push_back(memWord(a));
         waitFor(1'b0, 300, ok);
         if (!ok) break;
      end
      if_req = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      bit ok;
      int k, cyc;

      // Randomized mixed traffic with random memory latency and stray mem_done.
      doReset();
      memDelay = -1;
      spurious = 1'b1;
      fork
         dataDriver(60);
         fetchDriver(40);
      join
      repeat (4) @(negedge clk);
      spurious = 1'b0;

      // Lone data read: valid on the third cycle.
      doReset();
      memDelay = 0;
      d_rd = 1'b1; d_addr = 16'h0010;
      exp_q.push_back({1'b0, 16'hBEEF});
      @(negedge clk);
      chk("t1_mem_en_cycle2", mem_en, 1'b1);
      chk("t1_dvalid_cycle2", d_valid, 1'b0);
      @(negedge clk);
      chk("t1_dvalid_cycle3", d_valid, 1'b1);
      chk("t1_drdata_cycle3", d_rdata, 16'hBEEF);
      chk("t1_ifvalid_cycle3", if_valid, 1'b0);
      #2 d_rd = 1'b0;
      @(negedge clk);
      chk("t1_dvalid_cycle4", d_valid, 1'b0);

      // Both requesters held: every fifth grant goes to fetch.
      doReset();
      memDelay = 0;
      if_req = 1'b1; if_addr = 16'h8002;
      d_rd = 1'b1; d_addr = 16'h0020;
      repeat (8) exp_q.push_back({1'b0, memWord(16'h0020)});
      repeat (2) fexp_q.push_back(memWord(16'h8002));
      k = 0; cyc = 0;
      while (k < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (d_valid || if_valid) begin
            chk($sformatf("t2_grant%0d_is_fetch", k), if_valid, (k % 5 == 4));
            k++;
         end
      end
      if (k < 10) chk("t2_timeout", 0, 1);
      #2 if_req = 1'b0; d_rd = 1'b0;
      repeat (2) @(negedge clk);

      // Misaligned write: error pulse, no memory access.
      doReset();
      d_wr = 1'b1; d_addr = 16'h0003; d_wdata = 16'h1234;
      exp_q.push_back({1'b1, 16'h0000});
      @(negedge clk);
      chk("t3_d_err", d_err, 1'b1);
      chk("t3_d_valid", d_valid, 1'b1);
      chk("t3_d_rdata", d_rdata, 16'h0000);
      chk("t3_mem_en", mem_en, 1'b0);
      #2 d_wr = 1'b0;
      @(negedge clk);
      chk("t3_mem_en_after", mem_en, 1'b0);
      chk("t3_err_cleared", {d_err, d_valid}, 2'b00);

      // Halt mid-access: access completes, then a single dump cycle, then halted.
      doReset();
      memDelay = 5;
      d_rd = 1'b1; d_addr = 16'h0040;
      exp_q.push_back({1'b0, memWord(16'h0040)});
      @(negedge clk);
      chk("t4_in_dacc", mem_en, 1'b1);
      #2 halt = 1'b1;
      waitFor(1'b1, 50, ok);
      chk("t4_no_dump_with_valid", mem_createdump, 1'b0);
      d_rd = 1'b0;
      @(negedge clk);
      chk("t4_dump", mem_createdump, 1'b1);
      chk("t4_dump_mem_en", mem_en, 1'b0);
      @(negedge clk);
      chk("t4_dump_one_cycle", mem_createdump, 1'b0);
      #2 if_req = 1'b1; if_addr = 16'h8004;
      repeat (6) begin
         @(negedge clk);
         chk("t4_halted_mem_en", mem_en, 1'b0);
         chk("t4_halted_if_valid", if_valid, 1'b0);
         chk("t4_halted_if_stall", if_stall, 1'b1);
      end
      #2 if_req = 1'b0; halt = 1'b0;

      // Reset during a fetch: abandon it, then the held request is re-granted.
      doReset();
      memDelay = 10;
      if_req = 1'b1; if_addr = 16'h8010;
      fexp_q.push_back(memWord(16'h8010));
      @(negedge clk);
      chk("t5_in_facc", mem_en, 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_mem_en", mem_en, 1'b0);
      chk("t5_rst_mem_addr", mem_addr, 16'h0);
      chk("t5_rst_if_valid", if_valid, 1'b0);
      chk("t5_rst_if_rdata", if_rdata, 16'h0);
      @(negedge clk);
      chk("t5_rst_no_if_valid", if_valid, 1'b0);
      #2 memDelay = 0;
      rst = 1'b1;
      waitFor(1'b0, 50, ok);
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      chk("data_queue_drained", exp_q.size(), 0);
      chk("fetch_queue_drained", fexp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
